adder_share_ctrl: RTL and testbench

- Shares one WIDTH-bit adder/subtractor among NUM_REQ requesters, e.g. fetch PC increment, branch target and IRQ vector offset.
- Arbitration is round-robin over valid/ready request channels.
- Each operation is a single registered add or subtract; results return on one shared response channel tagged with the requester id.
- Each accepted result is emitted on the 36-bit trace port.

---
 rtl/adder_share_ctrl.sv | 138 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Shared adder/subtractor: round-robin arbitration over NUM_REQ request
// channels, one registered result slot, requester-tagged response, and a
// one-cycle trace pulse for every accepted result.
module adder_share_ctrl #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WIDTH        = 32,
  parameter bit          ENABLE_TRACE = 1'b1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  input  logic [NUM_REQ-1:0]           req_sub,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WIDTH-1:0]             resp_sum,
  output logic                         resp_cout,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  input  logic                         abort,
  output logic                         trace_valid,
  output logic [35:0]                  trace_data
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             trace_valid_q, trace_valid_d;
  logic [35:0]      trace_data_q, trace_data_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             sub_sel;
  logic             can_load;
  logic             grant;
  logic [WIDTH:0]   raw;

  // Round-robin search: first valid requester at or after ptr, with wrap
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] cand;
    found   = 1'b0;
    win     = '0;
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx  = (32'(ptr_q) + off) % NUM_REQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win     = cand;
        a_sel   = req_a[idx*WIDTH +: WIDTH];
        b_sel   = req_b[idx*WIDTH +: WIDTH];
        sub_sel = req_sub[cand];
      end
    end
  end

  // Grant gating and the shared arithmetic (subtract as A + ~B + 1)
  always_comb begin
    can_load  = resetn && !abort && ((state_q == IDLE) || resp_ready);
    grant     = can_load && found;
    req_ready = grant ? (NUM_REQ'(1) << win) : '0;
    raw       = {1'b0, a_sel} + {1'b0, (sub_sel ? ~b_sel : b_sel)}
              + {{WIDTH{1'b0}}, sub_sel};
  end

  // Next-state: abort flushes first, then load on grant, else drain
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
    id_d          = id_q;
    trace_valid_d = 1'b0;
    trace_data_d  = trace_data_q;

    if (ENABLE_TRACE && (state_q == FULL) && resp_ready && !abort) begin
      trace_valid_d = 1'b1;
      trace_data_d  = {4'b0100, 32'(sum_q)};
    end

    if (abort) begin
      state_d = IDLE;
    end else if (grant) begin
      state_d = FULL;
      sum_d   = raw[WIDTH-1:0];
      cout_d  = raw[WIDTH];
      id_d    = win;
      ptr_d   = IDW'((32'(win) + 1) % NUM_REQ);
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = IDLE;
    end
  end

  // State, result and trace registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      id_q          <= '0;
      trace_valid_q <= 1'b0;
      trace_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      id_q          <= id_d;
      trace_valid_q <= trace_valid_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign resp_valid  = (state_q == FULL);
  assign resp_sum    = sum_q;
  assign resp_cout   = cout_q;
  assign resp_id     = id_q;
  assign trace_valid = trace_valid_q;
  assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl (NUM_REQ=4, WIDTH=32): per-scenario tasks plus a
// scoreboard monitor that checks every accepted response and its trace pulse.
module tb_adder_share_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   req_valid, req_ready, req_sub;
  logic [127:0] req_a, req_b;
  logic         resp_valid, resp_ready, resp_cout;
  logic [31:0]  resp_sum;
  logic [1:0]   resp_id;
  logic         abort, trace_valid;
  logic [35:0]  trace_data;

  logic [31:0]  op_a [4];
  logic [31:0]  op_b [4];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        exp_trace;
  logic [35:0] exp_tdata;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
    end
  end

  adder_share_ctrl #(.NUM_REQ(4), .WIDTH(32), .ENABLE_TRACE(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id),
    .abort(abort), .trace_valid(trace_valid), .trace_data(trace_data)
  );

  // Scoreboard monitor: pops on every accepted response, checks trace one cycle later
  always @(negedge clk) begin
    if (!resetn) begin
      exp_trace = 1'b0;
    end else begin
      n_checks++;
      if (trace_valid !== exp_trace || (exp_trace && trace_data !== exp_tdata)) begin
        n_errors++;
        $display("FAIL trace: got valid=%0b data=%h, want valid=%0b data=%h",
                 trace_valid, trace_data, exp_trace, exp_tdata);
      end
      exp_trace = 1'b0;
      if (resp_valid && resp_ready && !abort) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL resp_unexpected: got id=%0d sum=%h, want no response", resp_id, resp_sum);
        end else begin
          mon_e = exp_q.pop_front();
          if (resp_id !== mon_e.id || resp_sum !== mon_e.sum || resp_cout !== mon_e.cout) begin
            n_errors++;
            $display("FAIL resp: got id=%0d sum=%h cout=%0b, want id=%0d sum=%h cout=%0b",
                     resp_id, resp_sum, resp_cout, mon_e.id, mon_e.sum, mon_e.cout);
          end
          exp_trace = 1'b1;
          exp_tdata = {4'b0100, mon_e.sum};
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference result from the requester's current operands
  task automatic push_exp(input int id);
    exp_t        e;
    logic [32:0] r;
    if (req_sub[id]) begin
      r      = {1'b0, op_a[id]} - {1'b0, op_b[id]};
      e.cout = ~r[32];
    end else begin
      r      = {1'b0, op_a[id]} + {1'b0, op_b[id]};
      e.cout = r[32];
    end
    e.sum = r[31:0];
    e.id  = 2'(id);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_sum !== 32'h0) begin n_errors++; $display("FAIL rst_sum: got %h want 0", resp_sum); end
    n_checks++; if (resp_cout !== 1'b0) begin n_errors++; $display("FAIL rst_cout: got %b want 0", resp_cout); end
    n_checks++; if (resp_id !== 2'd0) begin n_errors++; $display("FAIL rst_id: got %0d want 0", resp_id); end
    n_checks++; if (trace_valid !== 1'b0) begin n_errors++; $display("FAIL rst_tvalid: got %b want 0", trace_valid); end
    n_checks++; if (trace_data !== 36'h0) begin n_errors++; $display("FAIL rst_tdata: got %h want 0", trace_data); end
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    req_valid = 4'b0000;
  endtask

  task automatic test_single_add();
    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h1; req_sub[2] = 1'b0;
    req_valid = 4'b0100;
    push_exp(2);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL add_grant: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1) begin n_errors++; $display("FAIL add_valid: got %b want 1", resp_valid); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (trace_valid !== 1'b1 || trace_data !== 36'h4_0000_0000) begin
      n_errors++; $display("FAIL add_trace: got %b/%h want 1/400000000", trace_valid, trace_data);
    end
    next_cycle();
  endtask

  task automatic test_sub();
    op_a[3] = 32'd5; op_b[3] = 32'd7; req_sub[3] = 1'b1;
    req_valid = 4'b1000;
    push_exp(3);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL sub1_grant: got %b want 1000", req_ready); end
    next_cycle();
    op_a[0] = 32'd7; op_b[0] = 32'd5; req_sub[0] = 1'b1;
    req_valid = 4'b0001;
    push_exp(0);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL sub2_grant: got %b want 0001", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    req_sub   = 4'b0000;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_round_robin();
    int seq [6] = '{2, 3, 0, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 32'd1000 + 32'(i);
      op_b[i] = 32'(i * 3);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      int g;
      g = (1 + k) % 4;
      push_exp(g);
      @(negedge clk);
      n_checks++;
      if (req_ready !== (4'b0001 << g)) begin n_errors++; $display("FAIL rr_grant%0d: got %b want %0d", k, req_ready, g); end
      if (k > 0) begin
        n_checks++; if (resp_valid !== 1'b1) begin n_errors++; $display("FAIL rr_bubble%0d: got %b want 1", k, resp_valid); end
      end
      next_cycle();
    end
    req_valid = 4'b1101;
    for (int k = 0; k < 6; k++) begin
      push_exp(seq[k]);
      @(negedge clk);
      n_checks++;
      if (req_ready !== (4'b0001 << seq[k])) begin n_errors++; $display("FAIL rr_skip%0d: got %b want %0d", k, req_ready, seq[k]); end
      next_cycle();
    end
    req_valid = 4'b0000;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_backpressure();
    op_a[1] = 32'd4; op_b[1] = 32'd6;
    req_valid = 4'b0010;
    push_exp(1);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    next_cycle();
    resp_ready = 1'b0;
    op_a[2] = 32'd20; op_b[2] = 32'd3;
    req_valid = 4'b1100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_sum !== 32'd10 || resp_id !== 2'd1) begin
        n_errors++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b sum=%0d id=%0d want 0000/1/10/1",
                 k, req_ready, resp_valid, resp_sum, resp_id);
      end
      next_cycle();
    end
    resp_ready = 1'b1;
    push_exp(2);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL bp_release: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (trace_valid !== 1'b1 || trace_data !== 36'h4_0000_000A) begin
      n_errors++; $display("FAIL bp_trace: got %b/%h want 1/40000000a", trace_valid, trace_data);
    end
    next_cycle();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_abort();
    req_valid = 4'b0010;
    push_exp(1);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL ab_setup: got %b want 0010", req_ready); end
    next_cycle();
    op_a[3] = 32'h1234_0000; op_b[3] = 32'h0000_5678;
    req_valid  = 4'b1001;
    abort      = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL ab_nogrant: got %b want 0000", req_ready); end
    n_checks++; if (resp_valid !== 1'b1) begin n_errors++; $display("FAIL ab_full: got %b want 1", resp_valid); end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    next_cycle();
    abort = 1'b0;
    push_exp(3);
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL ab_flush: got %b want 0", resp_valid); end
    n_checks++; if (trace_valid !== 1'b0) begin n_errors++; $display("FAIL ab_notrace: got %b want 0", trace_valid); end
    n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL ab_ptr: got %b want 1000", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_async_reset();
    op_a[1] = 32'd100; op_b[1] = 32'd1;
    op_a[2] = 32'd200; op_b[2] = 32'd2;
    req_valid = 4'b0110;
    push_exp(1);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL ar_grant1: got %b want 0010", req_ready); end
    next_cycle();
    req_valid = 4'b0100;
    push_exp(2);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL ar_grant2: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = 4'b1010;
    n_checks++;
    if (resp_valid !== 1'b1 || trace_valid !== 1'b1) begin
      n_errors++; $display("FAIL ar_pre: got v=%b t=%b want 1/1", resp_valid, trace_valid);
    end
    #1;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL ar_valid: got %b want 0", resp_valid); end
    n_checks++; if (trace_valid !== 1'b0) begin n_errors++; $display("FAIL ar_tvalid: got %b want 0", trace_valid); end
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL ar_ready: got %b want 0000", req_ready); end
    next_cycle();
    resetn = 1'b1;
    push_exp(1);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL ar_first: got %b want 0010", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    resetn     = 1'b0;
    abort      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    req_sub    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    test_reset();
    test_single_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
